// File: rtl/cascade_result_packer.sv
// Gathers one phase/amplitude result per channel into a frame, double-buffers it,
// and streams it as {SYNC,frame_cnt}, ph[0], ac[0], ... over a valid/ready port.
module cascade_result_packer #(
    parameter int          CHANELS = 4,
    parameter logic [15:0] SYNC    = 16'hA5C3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_vld,
    input  logic [$clog2(CHANELS)-1:0] i_addr,
    input  logic signed [31:0]         i_ph,
    input  logic [31:0]                i_ac,
    output logic [31:0]                o_data,
    output logic                       o_vld,
    output logic                       o_last,
    input  logic                       o_rdy,
    output logic [15:0]                drop_cnt,
    output logic                       dup_err
);

    localparam int DATA_W = 32;
    localparam int AW     = $clog2(CHANELS);
    localparam int NW     = 2 * CHANELS + 1;
    localparam int IW     = $clog2(NW);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             widx_q, widx_d, nxt_idx;
    logic [AW-1:0]             ch_sel;
    logic [CHANELS-1:0]        fill_mask, mask_d;
    logic [15:0]               frame_cnt;
    logic [DATA_W-1:0]         data_d;
    logic                      vld_d, last_d;
    logic                      full, xfer, hs, addr_ok, wr_ok, drop;

    logic signed [DATA_W-1:0]  col_ph [CHANELS];
    logic [DATA_W-1:0]         col_ac [CHANELS];
    logic signed [DATA_W-1:0]  ob_ph  [CHANELS];
    logic [DATA_W-1:0]         ob_ac  [CHANELS];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full    = &fill_mask;
    assign xfer    = (state_q == IDLE) && full;
    assign hs      = o_vld && o_rdy;
    assign addr_ok = (int'(i_addr) < CHANELS);
    // The transfer edge empties the bank, so a result arriving on it is kept.
    assign wr_ok   = i_vld && addr_ok && (!full || xfer);
    assign drop    = i_vld && !wr_ok;

    always_comb begin
        mask_d = xfer ? '0 : fill_mask;
        if (wr_ok)
            mask_d[i_addr] = 1'b1;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full)          state_d = SEND;
            SEND:    if (hs && o_last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next value of the registered stream port
    always_comb begin
        widx_d  = widx_q;
        data_d  = o_data;
        vld_d   = o_vld;
        last_d  = o_last;
        nxt_idx = widx_q + IW'(1);
        ch_sel  = AW'((nxt_idx - IW'(1)) >> 1);
        case (state_q)
            IDLE: begin
                if (full) begin
                    widx_d = '0;
                    data_d = {SYNC, frame_cnt};
                    vld_d  = 1'b1;
                    last_d = 1'b0;
                end
            end
            SEND: begin
                if (hs) begin
                    if (o_last) begin
                        vld_d  = 1'b0;
                        last_d = 1'b0;
                    end else begin
                        widx_d = nxt_idx;
                        data_d = nxt_idx[0] ? ob_ph[ch_sel] : ob_ac[ch_sel];
                        last_d = (nxt_idx == IW'(NW - 1));
                    end
                end
            end
            default: ;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            widx_q    <= '0;
            o_data    <= '0;
            o_vld     <= 1'b0;
            o_last    <= 1'b0;
            fill_mask <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
            dup_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            o_data    <= data_d;
            o_vld     <= vld_d;
            o_last    <= last_d;
            fill_mask <= mask_d;
            if (xfer)
                frame_cnt <= frame_cnt + 16'd1;
            if (drop)
                drop_cnt <= sat_inc16(drop_cnt);
            if (wr_ok && !xfer && fill_mask[i_addr])
                dup_err <= 1'b1;
        end
    end

    // Collection and output banks hold data only and need no reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            col_ph[i_addr] <= i_ph;
            col_ac[i_addr] <= i_ac;
        end
        if (xfer) begin
            for (int k = 0; k < CHANELS; k++) begin
                ob_ph[k] <= col_ph[k];
                ob_ac[k] <= col_ac[k];
            end
        end
    end

endmodule

// File: tb/tb_cascade_result_packer.sv
// Directed bench for cascade_result_packer: a queue-based frame model checked every
// cycle, plus literal expectations taken from hand-computed frames.
module tb_cascade_result_packer;

    localparam int CH = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               i_vld = 1'b0;
    logic [1:0]         i_addr = '0;
    logic signed [31:0] i_ph = '0;
    logic [31:0]        i_ac = '0;
    logic [31:0]        o_data;
    logic               o_vld, o_last;
    logic               o_rdy = 1'b0;
    logic [15:0]        drop_cnt;
    logic               dup_err;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 1;
    int rdy_k = 0;

    localparam logic [31:0] EXP1 [9] = '{32'hA5C30000, 32'hFFFFFFFF, 32'h0000000A,
                                          32'h00000002, 32'h00000014, 32'hFFFFFFFD,
                                          32'h0000001E, 32'h00000004, 32'h00000028};

    // Behavioural model: collection contents, pending output words, counters
    logic [31:0] m_ph [CH];
    logic [31:0] m_ac [CH];
    bit          m_mask [CH];
    logic [15:0] m_fcnt = '0;
    logic [15:0] m_drop = '0;
    bit          m_dup = 1'b0;
    logic [31:0] m_out [$];
    logic [31:0] log_w [$];
    bit          log_l [$];
    logic        p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
    logic [31:0] p_data = '0;

    cascade_result_packer #(.CHANELS(CH), .SYNC(16'hA5C3)) dut (
        .clk(clk), .rstn(rstn), .i_vld(i_vld), .i_addr(i_addr), .i_ph(i_ph),
        .i_ac(i_ac), .o_data(o_data), .o_vld(o_vld), .o_last(o_last),
        .o_rdy(o_rdy), .drop_cnt(drop_cnt), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ready pattern: 0 = low, 1 = high, 2 = repeating 1,0,0
    initial forever begin
        @(posedge clk); #2;
        case (rdy_mode)
            0: o_rdy = 1'b0;
            1: o_rdy = 1'b1;
            default: begin o_rdy = (rdy_k % 3 == 0); rdy_k++; end
        endcase
    end

    always @(negedge clk) begin
        bit hs, full, xfer;
        int a;
        if (!rstn) begin
            for (int k = 0; k < CH; k++) m_mask[k] = 1'b0;
            m_fcnt = '0; m_drop = '0; m_dup = 1'b0;
            m_out.delete();
            chk("rst_o_vld", {31'd0, o_vld}, 32'd0);
            chk("rst_o_last", {31'd0, o_last}, 32'd0);
            chk("rst_o_data", o_data, 32'd0);
            chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
            chk("rst_dup_err", {31'd0, dup_err}, 32'd0);
            p_vld = 1'b0;
        end else begin
            chk("o_vld", {31'd0, o_vld}, {31'd0, m_out.size() > 0});
            if (m_out.size() > 0) begin
                chk("o_data", o_data, m_out[0]);
                chk("o_last", {31'd0, o_last}, {31'd0, m_out.size() == 1});
            end
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop});
            chk("dup_err", {31'd0, dup_err}, {31'd0, m_dup});
            if (p_vld && !p_rdy) begin
                chk("hold_data", o_data, p_data);
                chk("hold_vld", {31'd0, o_vld}, 32'd1);
                chk("hold_last", {31'd0, o_last}, {31'd0, p_last});
            end
            p_vld = o_vld; p_rdy = o_rdy; p_data = o_data; p_last = o_last;

            // Advance the model across the coming rising edge
            hs = (m_out.size() > 0) && o_rdy;
            full = 1'b1;
            for (int k = 0; k < CH; k++) full &= m_mask[k];
            xfer = (m_out.size() == 0) && full;
            if (hs) begin
                log_w.push_back(o_data);
                log_l.push_back(o_last);
                void'(m_out.pop_front());
            end
            if (xfer) begin
                m_out.push_back({16'hA5C3, m_fcnt});
                for (int k = 0; k < CH; k++) begin
                    m_out.push_back(m_ph[k]);
                    m_out.push_back(m_ac[k]);
                    m_mask[k] = 1'b0;
                end
                m_fcnt = m_fcnt + 16'd1;
            end
            if (i_vld) begin
                a = int'(i_addr);
                if (a >= CH || (full && !xfer)) begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    if (m_mask[a]) m_dup = 1'b1;
                    m_ph[a] = i_ph;
                    m_ac[a] = i_ac;
                    m_mask[a] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input logic [31:0] p, input logic [31:0] c);
        i_vld = 1'b1; i_addr = a[1:0]; i_ph = p; i_ac = c;
        tick();
        i_vld = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int b;
        b = 0;
        while (log_w.size() < n && b < 300) begin tick(); b++; end
        chk("wait_timeout", {31'd0, log_w.size() >= n}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3; rstn = 1'b0;
        @(negedge clk);
        @(posedge clk); #3; rstn = 1'b1;
        tick();
    endtask

    task automatic basic_frame();
        wr(0, 32'hFFFFFFFF, 10);
        wr(1, 2, 20);
        wr(2, 32'hFFFFFFFD, 30);
        wr(3, 4, 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("init_o_vld", {31'd0, o_vld}, 32'd0);
        chk("init_o_data", o_data, 32'd0);

        // Plain frame with o_rdy high
        basic_frame();
        tick();
        chk("latency_vld", {31'd0, o_vld}, 32'd1);
        chk("latency_hdr", o_data, 32'hA5C30000);
        wait_log(9);
        for (int i = 0; i < 9; i++) begin
            chk("t1_word", log_w[i], EXP1[i]);
            chk("t1_last", {31'd0, log_l[i]}, {31'd0, i == 8});
        end
        chk("t1_drop", {16'd0, drop_cnt}, 32'd0);
        chk("t1_dup", {31'd0, dup_err}, 32'd0);
        repeat (3) tick();

        // Same frame under back-pressure
        log_w.delete(); log_l.delete();
        rdy_mode = 2;
        basic_frame();
        wait_log(9);
        chk("t2_count", log_w.size(), 32'd9);
        chk("t2_hdr", log_w[0], 32'hA5C30001);
        for (int i = 1; i < 9; i++) chk("t2_word", log_w[i], EXP1[i]);
        rdy_mode = 1;
        repeat (4) tick();

        // Duplicate write to ch2
        log_w.delete(); log_l.delete();
        wr(2, 7, 70);
        wr(0, 5, 50);
        chk("t3_dup_pre", {31'd0, dup_err}, 32'd0);
        wr(2, 9, 90);
        chk("t3_dup", {31'd0, dup_err}, 32'd1);
        wr(1, 6, 60);
        wr(3, 8, 80);
        wait_log(9);
        chk("t3_hdr", log_w[0], 32'hA5C30002);
        chk("t3_ph2", log_w[5], 32'd9);
        chk("t3_ac2", log_w[6], 32'd90);
        repeat (3) tick();

        // Stalled sink: second frame waits, further results are dropped
        do_reset();
        log_w.delete(); log_l.delete();
        rdy_mode = 0;
        repeat (2) tick();
        for (int k = 0; k < CH; k++) wr(k, 32'h100 + k, 32'h200 + k);
        for (int k = 0; k < CH; k++) wr(k, 32'h300 + k, 32'h400 + k);
        wr(0, 1, 1); wr(1, 1, 1); wr(2, 1, 1);
        chk("t4_drop", {16'd0, drop_cnt}, 32'd3);
        chk("t4_stall_hdr", o_data, 32'hA5C30000);
        rdy_mode = 1;
        wait_log(18);
        chk("t4_hdr_a", log_w[0], 32'hA5C30000);
        chk("t4_hdr_b", log_w[9], 32'hA5C30001);
        chk("t4_b_ph0", log_w[10], 32'h300);
        repeat (3) tick();

        // Result arriving on the transfer edge lands in the next frame
        log_w.delete(); log_l.delete();
        for (int k = 0; k < CH; k++) wr(k, 32'h500 + k, 32'h600 + k);
        wr(1, 555, 777);
        wr(0, 11, 12);
        wr(2, 13, 14);
        wr(3, 15, 16);
        wait_log(18);
        chk("t5_first_ph1", log_w[3], 32'h501);
        chk("t5_next_hdr", log_w[9], 32'hA5C30003);
        chk("t5_next_ph1", log_w[12], 32'd555);
        chk("t5_next_ac1", log_w[13], 32'd777);
        chk("t5_drop", {16'd0, drop_cnt}, 32'd3);
        repeat (3) tick();

        // Asynchronous reset in the middle of a frame
        log_w.delete(); log_l.delete();
        basic_frame();
        wait_log(4);
        chk("t6_mid_vld", {31'd0, o_vld}, 32'd1);
        #1 rstn = 1'b0;
        #1 chk("t6_async_vld", {31'd0, o_vld}, 32'd0);
        @(negedge clk);
        @(posedge clk); #3; rstn = 1'b1;
        tick();
        log_w.delete(); log_l.delete();
        basic_frame();
        wait_log(9);
        chk("t6_hdr", log_w[0], 32'hA5C30000);
        chk("t6_last_word", log_w[8], 32'h28);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cascade_result_packer.md
# cascade_result_packer

Collects per-channel phase/amplitude results from `computing_cascade` (`ph`, `ac`, `o_vld`, `address_output`) into a frame covering every channel. Double-buffers each frame and streams it out as 32-bit words over a valid/ready interface to the host/UART/DMA side. Sits directly downstream of `computing_cascade`. Reports dropped and duplicated results.

## Interface
- `CHANELS`, 4, number of channels per frame; must be ≥2.
- `SYNC`, 16'hA5C3, constant placed in the upper half of the header word.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `i_vld`  in  1  result strobe from the cascade `o_vld`.
- `i_addr`  in  $clog2(CHANELS)  channel of the current result (cascade `address_output`).
- `i_ph`  in  32 signed  phase difference.
- `i_ac`  in  32 unsigned  amplitude.
- `o_data`  out  32  stream word.
- `o_vld`  out  1  word valid.
- `o_last`  out  1  final word of frame.
- `o_rdy`  in  1  sink ready.
- `drop_cnt`  out  16  saturating count of dropped results.
- `dup_err`  out  1  sticky: a channel was written twice within one collection.

## Operation
- Collection bank: `CHANELS` × {ph, ac} registers plus a `fill_mask[CHANELS-1:0]`.
- Write rule when `i_vld` = 1:
  - If the collection bank is not full, store ph/ac at `i_addr` and set `fill_mask[i_addr]`.
  - If `fill_mask[i_addr]` was already 1, overwrite the stored value and set `dup_err`.
  - If `i_addr` ≥ `CHANELS`, ignore the write and increment `drop_cnt`.
- Full means `fill_mask` is all ones.
- While full and not yet transferred, every `i_vld` is dropped. Each drop increments `drop_cnt`, which saturates at 16'hFFFF.
- Output bank: a copy of the collection data plus a 16-bit `frame_cnt` snapshot.
- Output FSM states:
  - IDLE → SEND on the edge where the collection is full. That edge copies the bank, clears `fill_mask`, and latches `frame_cnt`.
  - SEND → IDLE on the handshake of the last word.
- Transfer happens only in IDLE. If full while SEND is active, transfer happens on the edge after the last-word handshake, giving one IDLE cycle.
- `i_vld` on the transfer edge writes into the freshly cleared bank, so afterwards `fill_mask` holds only that bit. The write is not dropped.
- Word order per frame:
  - Word 0 (header): {SYNC, frame_cnt}.
  - Then for k = 0..CHANELS-1: ph[k], ac[k].
  - Total 1 + 2·CHANELS words; `o_last` is set on the final word.
- `frame_cnt` increments by 1 at every transfer and wraps 16'hFFFF → 0. The first frame after reset carries 0.
- Handshake: a word moves when `o_vld && o_rdy`.
  - `o_data`, `o_vld`, and `o_last` are stable while `o_vld && !o_rdy`.
  - `o_vld` never drops before the handshake.
  - Words within a frame are back-to-back when `o_rdy` = 1.
- Reset (async, any time, including mid-frame): the in-flight frame is discarded, not resumed.
  - Outputs go to `o_vld`=0, `o_last`=0, `o_data`=0, `drop_cnt`=0, `dup_err`=0.
  - Internal state goes to `fill_mask`=0, `frame_cnt`=0, FSM = IDLE.

## Timing
- All outputs are registered.
- Latency: the `i_vld` completing the mask is sampled at edge E0. Full is visible after E0. Transfer happens at E1 (if IDLE), and the header is on `o_data` with `o_vld`=1 after E1.
- With `o_rdy` held 1, a frame occupies 1 + 2·CHANELS consecutive cycles; for CHANELS=4 that is 9 cycles.
- Minimum frame period is 2·CHANELS + 2 cycles, including the IDLE gap.
- Throughput: the upstream cascade delivers at most one result per cycle. With CHANELS=4, a back-to-back input period of 4 cycles is shorter than the 10-cycle output period, so drops are expected under continuous full-rate input. That is the designed behaviour, and `drop_cnt` reflects it.
- `drop_cnt` and `dup_err` update on the edge after the offending `i_vld`.

## Test plan
- Reset, then write ch0..3 once, with ph = −1, 2, −3, 4 and ac = 10, 20, 30, 40, while `o_rdy`=1.
  - Two cycles after the last write, expect 9 words: A5C30000, FFFFFFFF, 0000000A, 00000002, 00000014, FFFFFFFD, 0000001E, 00000004, 00000028.
  - `o_last` is asserted only on the 9th word; `drop_cnt`=0 and `dup_err`=0.
- Same frame with `o_rdy` toggling 1,0,0,1,…
  - Each word is held unchanged during the 0 cycles.
  - Word sequence and count are identical to the first test.
- Writes in order ch2, ch0, ch2 (ph=7, then ph=9), ch1, ch3.
  - `dup_err`=1 after the third write.
  - The frame outputs ph[2]=9.
- Hold `o_rdy`=0 after frame 1 transfers, complete frame 2, then issue 3 more `i_vld`.
  - `drop_cnt`=3.
  - Release `o_rdy`: frame 1 header …0000, then frame 2 header …0001.
- Assert `i_vld` for ch1 on the transfer edge.
  - The next frame needs only ch0, ch2, ch3 to fill.
  - The ch1 value appears in that next frame.
- Pull `rstn` low during word 4 of a frame.
  - `o_vld`=0 immediately (asynchronously).
  - After release, the next complete frame has header A5C30000.
